// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle unsigned 16x16->32 multiply and 16/16 divide
// sequencer that borrows the shared combinational ALU, one ALU operation per
// iteration.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   start, op, a, b         request pulse (IDLE only); op 0 = mul, 1 = div
//   busy, done              busy in LOAD/ITER; one-cycle done pulse in DONE
//   result_hi, result_lo    mul: product hi/lo; div: remainder/quotient
//   alu_bus, alu_y, alu_ctrl   operands and opcode driven to the ALU
//   alu_result              ALU output, same-cycle combinational
//   div_err                 only with ALU_SEQ_DIVZERO_EN: divide-by-zero flag
//
// Optional feature macro: ALU_SEQ_DIVZERO_EN (short-circuits divide by zero).
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] alu_bus,
    output logic [WIDTH-1:0] alu_y,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result
`ifdef ALU_SEQ_DIVZERO_EN
    ,
    output logic             div_err
`endif
);

    localparam logic [2:0] CTRL_ADD   = 3'b000;
    localparam logic [2:0] CTRL_SUB   = 3'b110;
    localparam logic [2:0] CTRL_PASSY = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef ALU_SEQ_DIVZERO_EN
    logic             err_q, err_d;
`endif

    logic [WIDTH-1:0] alu_bus_c, alu_y_c;
    logic [2:0]       alu_ctrl_c;
    logic [WIDTH-1:0] r_shift;
    logic             carry;
    logic             qbit;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SEQ_DIVZERO_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ALU_SEQ_DIVZERO_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state, iteration datapath and ALU drive
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        alu_bus_c  = '0;
        alu_y_c    = '0;
        alu_ctrl_c = CTRL_PASSY;
        carry      = 1'b0;
        qbit       = 1'b0;
`ifdef ALU_SEQ_DIVZERO_EN
        err_d      = err_q;
`endif
        // Partial remainder shifted left by one, pulling in the next dividend bit
        r_shift    = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};

        case (state_q)
            S_IDLE: begin
                // Operands are only valid alongside start, so capture them here
                if (start) begin
                    state_d = S_LOAD;
                    op_d    = op;
                    hi_d    = '0;
                    lo_d    = a;
                    m_d     = b;
                    cnt_d   = '0;
`ifdef ALU_SEQ_DIVZERO_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                state_d = S_ITER;
                cnt_d   = '0;
`ifdef ALU_SEQ_DIVZERO_EN
                // Divide by zero: skip iterating, report saturated quotient
                if (op_q && (m_q == '0)) begin
                    state_d = S_DONE;
                    hi_d    = lo_q;
                    lo_d    = '1;
                    err_d   = 1'b1;
                end
`endif
            end
            S_ITER: begin
                if (!op_q) begin
                    // Shift-add multiply; the lost carry is recovered by unsigned compare
                    alu_bus_c  = hi_q;
                    alu_y_c    = lo_q[0] ? m_q : '0;
                    alu_ctrl_c = CTRL_ADD;
                    carry      = (alu_result < hi_q);
                    hi_d       = {carry, alu_result[WIDTH-1:1]};
                    lo_d       = {alu_result[0], lo_q[WIDTH-1:1]};
                end else begin
                    // Restoring divide; a set top bit means r' already exceeds m
                    alu_bus_c  = r_shift;
                    alu_y_c    = m_q;
                    alu_ctrl_c = CTRL_SUB;
                    qbit       = hi_q[WIDTH-1] || (r_shift >= m_q);
                    hi_d       = qbit ? alu_result : r_shift;
                    lo_d       = {lo_q[WIDTH-2:0], qbit};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_ITER);
        done_d = (state_d == S_DONE);
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_hi = hi_q;
    assign result_lo = lo_q;
    assign alu_bus   = alu_bus_c;
    assign alu_y     = alu_y_c;
    assign alu_ctrl  = alu_ctrl_c;
`ifdef ALU_SEQ_DIVZERO_EN
    assign div_err   = err_q;
`endif

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: bench-side ALU, cycle-level behavioural model of
// the request/response timing, per-cycle output compare, directed literals.
module tb_alu_muldiv_seq;

    localparam int unsigned W = 16;
`ifdef ALU_SEQ_DIVZERO_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] result_hi, result_lo;
    logic [W-1:0] alu_bus, alu_y, alu_result;
    logic [2:0]   alu_ctrl;
`ifdef ALU_SEQ_DIVZERO_EN
    logic         div_err;
`endif

    alu_muldiv_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result_hi  (result_hi),
        .result_lo  (result_lo),
        .alu_bus    (alu_bus),
        .alu_y      (alu_y),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result)
`ifdef ALU_SEQ_DIVZERO_EN
        ,
        .div_err    (div_err)
`endif
    );

    always #5 clk = ~clk;

    // Shared ALU as seen by the sequencer
    always_comb begin
        case (alu_ctrl)
            3'b000:  alu_result = alu_bus + alu_y;
            3'b110:  alu_result = alu_bus - alu_y;
            3'b101:  alu_result = alu_y;
            default: alu_result = '0;
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference, returned as {hi, lo}
    function automatic logic [31:0] ref_result(input bit o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [31:0] r;
        if (!o)          r = {16'h0000, x} * {16'h0000, y};
        else if (y == 0) r = {x, 16'hFFFF};
        else             r = {x % y, x / y};
        return r;
    endfunction

    function automatic int exp_lat(input bit o, input logic [W-1:0] y);
        return (DZ_EN && o && (y == 0)) ? 1 : 17;
    endfunction

    // Behavioural model: edges since the accepted start, plus pending answer
    bit           m_run  = 1'b0;
    int           m_cyc  = 0;
    int           m_len  = 17;
    bit           m_op   = 1'b0;
    logic [W-1:0] m_b    = '0;
    logic [W-1:0] exp_hi = '0, exp_lo = '0;
    logic [W-1:0] pend_hi = '0, pend_lo = '0;
    bit           exp_err = 1'b0, pend_err = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run   = 1'b0;
            m_cyc   = 0;
            exp_hi  = '0;
            exp_lo  = '0;
            exp_err = 1'b0;
        end else if (!m_run) begin
            if (start) begin
                m_run    = 1'b1;
                m_cyc    = 0;
                m_op     = op;
                m_b      = b;
                {pend_hi, pend_lo} = ref_result(op, a, b);
                pend_err = DZ_EN && op && (b == 0);
                m_len    = exp_lat(op, b);
                exp_err  = 1'b0;
            end
        end else begin
            m_cyc++;
            if (m_cyc == m_len) begin
                exp_hi  = pend_hi;
                exp_lo  = pend_lo;
                exp_err = pend_err;
            end else if (m_cyc > m_len) begin
                m_run = 1'b0;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin : cmp
        bit e_busy, e_done, e_iter;
        if (!reset) begin
            e_busy = m_run && (m_cyc < m_len);
            e_done = m_run && (m_cyc == m_len);
            e_iter = m_run && (m_cyc >= 1) && (m_cyc < m_len);
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("alu_ctrl", alu_ctrl, e_iter ? (m_op ? 3'b110 : 3'b000) : 3'b101);
            if (!e_iter) begin
                check("alu_bus_idle", alu_bus, 0);
                check("alu_y_idle", alu_y, 0);
            end else if (m_op) begin
                check("alu_y_div", alu_y, m_b);
            end else begin
                check("alu_y_mul", (alu_y == 0) || (alu_y == m_b), 1);
            end
            if (!e_busy) begin
                check("result_hi", result_hi, exp_hi);
                check("result_lo", result_lo, exp_lo);
            end
`ifdef ALU_SEQ_DIVZERO_EN
            check("div_err", div_err, exp_err);
`endif
        end
    end

    // Issue one operation; optionally pulse a stray start at a given cycle
    task automatic run_op(input bit o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int glitch_at, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = 1'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            if (lat == glitch_at) begin
                start = 1'b1; op = ~o; a = W'($urandom); b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("latency", lat, exp_lat(o, y));
    endtask

    int lat;
    logic [W-1:0] rb;

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ctrl", alu_ctrl, 3'b101);
        check("rst_hi", result_hi, 0);
        check("rst_lo", result_lo, 0);
        #1 reset = 1'b0;

        run_op(1'b0, 16'h1234, 16'h0010, -1, lat);
        check("mul1_hi", result_hi, 16'h0001);
        check("mul1_lo", result_lo, 16'h2340);

        run_op(1'b0, 16'hFFFF, 16'hFFFF, -1, lat);
        check("mul2_hi", result_hi, 16'hFFFE);
        check("mul2_lo", result_lo, 16'h0001);

        run_op(1'b1, 16'd1000, 16'd7, -1, lat);
        check("div1_q", result_lo, 16'h008E);
        check("div1_r", result_hi, 16'h0006);

        run_op(1'b1, 16'h8000, 16'd3, -1, lat);
        check("div2_q", result_lo, 16'h2AAA);
        check("div2_r", result_hi, 16'h0002);

        run_op(1'b1, 16'h1234, 16'h0000, -1, lat);
        check("div0_q", result_lo, 16'hFFFF);
        check("div0_r", result_hi, 16'h1234);
`ifdef ALU_SEQ_DIVZERO_EN
        check("div0_err", div_err, 1);
`endif

        // Stray start at counter 5 is ignored; next start right after done
        run_op(1'b0, 16'h00FF, 16'h0101, 6, lat);
        check("glitch_hi", result_hi, 16'h0000);
        check("glitch_lo", result_lo, 16'hFFFF);
        run_op(1'b1, 16'hABCD, 16'h0012, -1, lat);
        check("b2b_q", result_lo, 16'h098B);
        check("b2b_r", result_hi, 16'h0007);

        // Reset while counter = 8
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h3333; b = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_ctrl", alu_ctrl, 3'b101);
        check("mid_rst_bus", alu_bus, 0);
        check("mid_rst_hi", result_hi, 0);
        check("mid_rst_lo", result_lo, 0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        run_op(1'b0, 16'h3333, 16'h0007, -1, lat);
        check("post_rst_hi", result_hi, 16'h0001);
        check("post_rst_lo", result_lo, 16'h6665);

        // Randomized operations checked by the model
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                2:       rb = 16'hFFFF;
                default: rb = W'($urandom);
            endcase
            run_op(1'($urandom), W'($urandom), rb, -1, lat);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that time-shares the combinational 16-bit ALU to perform unsigned 16x16->32 multiply and 16/16 divide. It drives the ALU operand and opcode inputs each cycle and captures ALU_out into internal accumulators. It sits beside the main control unit, which issues a start pulse and waits for done while the ALU is otherwise unused.

Parameters:
WIDTH, 16, datapath/ALU operand width; the iteration count equals WIDTH.
CNT_W, 5, width of the iteration counter; must hold values 0..WIDTH.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request pulse; sampled only in IDLE.
op  in  1  0 = multiply, 1 = divide; sampled with start.
a  in  WIDTH  multiplicand or dividend; sampled with start.
b  in  WIDTH  multiplier or divisor; sampled with start.
busy  out  1  high in LOAD and ITER states.
done  out  1  one-cycle pulse in DONE state.
result_hi  out  WIDTH  multiply: product[31:16]; divide: remainder.
result_lo  out  WIDTH  multiply: product[15:0]; divide: quotient.
alu_bus  out  WIDTH  to ALU bus operand.
alu_y  out  WIDTH  to ALU y_shifted operand.
alu_ctrl  out  3  to ALU_control.
alu_result  in  WIDTH  from ALU_out, same-cycle combinational.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all accumulators 0; busy=0, done=0, result_hi/lo=0, alu_bus=0, alu_y=0, alu_ctrl=3'b101 (pass Y).
- States: IDLE -> LOAD on start; LOAD -> ITER; ITER -> DONE when counter reaches WIDTH-1; DONE -> IDLE unconditionally.
- LOAD: latch op, hi=0, lo=a, operand reg m=b, counter=0.
- Multiply ITER: alu_bus=hi, alu_y = lo[0] ? m : 0, alu_ctrl=3'b000 (add). Carry = (alu_result < hi), unsigned. Update {hi,lo} <= {carry, alu_result, lo[WIDTH-1:1]}.
- Divide ITER: r' = {hi[WIDTH-2:0], lo[WIDTH-1]}, top = hi[WIDTH-1]; alu_bus=r', alu_y=m, alu_ctrl=3'b110 (subtract). If top=1 or r' >= m: hi<=alu_result, qbit=1; else hi<=r', qbit=0. lo <= {lo[WIDTH-2:0], qbit}.
- Latency: start sampled at edge E0; LOAD during E0..E1; ITER iterations at edges E2..E17; done high between E17 and E18 (17 edges after start). Back-to-back: start may be presented in the cycle after done.
- result_hi/lo reflect the internal accumulators; valid from the DONE cycle and held unchanged in IDLE until the next start is accepted.
- start while busy or in DONE: ignored, no effect on the running operation.
- Divide by zero (m=0): runs the normal 16 iterations; subtracting 0 always succeeds, giving quotient 0xFFFF and remainder = a.
- In IDLE, LOAD and DONE, ALU outputs are held at the reset values.
- Reset asserted mid-operation: abandon immediately; no done pulse is issued; results are cleared to 0.

Optional Feature:
ALU_SEQ_DIVZERO_EN: when defined, an extra output div_err (1 bit) is present. A divide with b=0 goes LOAD -> DONE directly, skipping ITER, so done is high between E1 and E2. div_err=1 together with done, result_lo=0xFFFF, result_hi=a. div_err is cleared on reset and on the next accepted start. When not defined: no div_err port, and a divide by zero takes the full-length path described above.

Test Plan:
- Multiply a=0x1234, b=0x0010 -> done 17 edges after start; result_hi=0x0001, result_lo=0x2340; alu_ctrl=000 throughout ITER.
- Multiply a=0xFFFF, b=0xFFFF -> result_hi=0xFFFE, result_lo=0x0001 (exercises carry recovery).
- Divide a=1000, b=7 -> result_lo=0x008E, result_hi=0x0006; divide a=0x8000, b=3 -> 0x2AAA remainder 0x0002.
- Divide a=0x1234, b=0 -> result_lo=0xFFFF, result_hi=0x1234; with ALU_SEQ_DIVZERO_EN: done 1 edge after LOAD with div_err=1; without it: 17-edge latency.
- Pulse start again at ITER counter=5 with different a/b -> ignored, original result unchanged; new start in the cycle after done is accepted.
- Assert reset at counter=8 -> busy=0, done never pulses, results=0, alu_ctrl=101 immediately (async); next operation after release is correct.
